// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - operand/result handshake bundle between loader and arithmetic core
interface operand_loader_if #(
    parameter int NUM_OPERANDS = 2,
    parameter int OPERAND_W    = 32,
    parameter int RESULT_W     = 32
);
    logic [NUM_OPERANDS*OPERAND_W-1:0] operands;
    logic                              operands_valid;
    logic                              operands_ready;
    logic [RESULT_W-1:0]               result;
    logic                              result_valid;

    // Loader side: offers operands, receives the result.
    modport master (
        output operands,
        output operands_valid,
        input  operands_ready,
        input  result,
        input  result_valid
    );

    // Core side: consumes operands, returns the result.
    modport slave (
        input  operands,
        input  operands_valid,
        output operands_ready,
        output result,
        output result_valid
    );
endinterface

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - button-driven operand entry, core handshake and result paging
module operand_loader #(
    parameter int DATA_W       = 8,
    parameter int OPERAND_W    = 32,
    parameter int NUM_OPERANDS = 2,
    parameter int RESULT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_next_i,
    input  logic              btn_back_i,
    input  logic [DATA_W-1:0] data_i,
    operand_loader_if.master  core_if,
    output logic              loaddata_o,
    output logic [DATA_W-1:0] disp_byte_o,
    output logic [3:0]        disp_tag_o,
    output logic [3:0]        disp_index_o
);

    localparam int BYTES  = OPERAND_W / DATA_W;
    localparam int RBYTES = RESULT_W / DATA_W;
    localparam int OPS_W  = NUM_OPERANDS * OPERAND_W;

    localparam logic [2:0] OP_LAST    = 3'(NUM_OPERANDS - 1);
    localparam logic [3:0] BYTE_LAST  = 4'(BYTES - 1);
    localparam logic [3:0] RBYTE_LAST = 4'(RBYTES - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_VIEW
    } state_t;

    // Button conditioning: [0],[1] synchronise, [2] holds the previous
    // synchronised level for edge detection.
    logic [2:0] next_sync_q;
    logic [2:0] back_sync_q;
    logic       next_pulse_q;
    logic       back_pulse_q;

    state_t            state_q,   state_d;
    logic [2:0]        op_q,      op_d;
    logic [3:0]        byte_q,    byte_d;
    logic [3:0]        vbyte_q,   vbyte_d;
    logic [OPS_W-1:0]  operands_q, operands_d;
    logic [RESULT_W-1:0] result_q, result_d;

    logic next_ev;
    logic back_ev;
    int   wr_lsb;
    int   rd_lsb;

    // Synchronise buttons and register a one-cycle pulse on each rising edge.
    // Reset fills the chains with ones, so a button already down when reset
    // releases looks like it was always down and cannot produce a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_sync_q  <= 3'b111;
            back_sync_q  <= 3'b111;
            next_pulse_q <= 1'b0;
            back_pulse_q <= 1'b0;
        end else begin
            next_sync_q  <= {next_sync_q[1:0], btn_next_i};
            back_sync_q  <= {back_sync_q[1:0], btn_back_i};
            next_pulse_q <= next_sync_q[1] & ~next_sync_q[2];
            back_pulse_q <= back_sync_q[1] & ~back_sync_q[2];
        end
    end

    // Simultaneous next and back presses cancel each other.
    assign next_ev = next_pulse_q & ~back_pulse_q;
    assign back_ev = back_pulse_q & ~next_pulse_q;

    // State, entry position, operand storage and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            op_q       <= 3'd0;
            byte_q     <= 4'd0;
            vbyte_q    <= 4'd0;
            operands_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            byte_q     <= byte_d;
            vbyte_q    <= vbyte_d;
            operands_q <= operands_d;
            result_q   <= result_d;
        end
    end

    // Next-state logic: byte entry, handshake, result capture, paging.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        byte_d     = byte_q;
        vbyte_d    = vbyte_q;
        operands_d = operands_q;
        result_d   = result_q;
        wr_lsb     = (int'(op_q) * BYTES + int'(byte_q)) * DATA_W;

        case (state_q)
            S_LOAD: begin
                if (next_ev) begin
                    operands_d[wr_lsb +: DATA_W] = data_i;
                    if (byte_q == BYTE_LAST) begin
                        byte_d = 4'd0;
                        if (op_q == OP_LAST) begin
                            op_d    = 3'd0;
                            state_d = S_SEND;
                        end else begin
                            op_d = op_q + 3'd1;
                        end
                    end else begin
                        byte_d = byte_q + 4'd1;
                    end
                end else if (back_ev) begin
                    // Step back one byte; stored contents are left for the
                    // next press to overwrite.
                    if (byte_q != 4'd0) begin
                        byte_d = byte_q - 4'd1;
                    end else if (op_q != 3'd0) begin
                        op_d   = op_q - 3'd1;
                        byte_d = BYTE_LAST;
                    end
                end
            end

            S_SEND: begin
                // A transfer already under way takes priority over a withdraw.
                if (core_if.operands_ready) begin
                    state_d = S_WAIT;
                end else if (back_ev) begin
                    state_d = S_LOAD;
                    op_d    = OP_LAST;
                    byte_d  = BYTE_LAST;
                end
            end

            S_WAIT: begin
                if (core_if.result_valid) begin
                    result_d = core_if.result;
                    vbyte_d  = 4'd0;
                    state_d  = S_VIEW;
                end
            end

            S_VIEW: begin
                if (next_ev) begin
                    vbyte_d = (vbyte_q == RBYTE_LAST) ? 4'd0 : vbyte_q + 4'd1;
                end else if (back_ev) begin
                    operands_d = '0;
                    op_d       = 3'd0;
                    byte_d     = 4'd0;
                    state_d    = S_LOAD;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign core_if.operands       = operands_q;
    assign core_if.operands_valid = (state_q == S_SEND);
    assign loaddata_o             = (state_q == S_LOAD);

    // Display decode; only the live switch word bypasses registered state.
    always_comb begin
        disp_byte_o  = '0;
        disp_tag_o   = 4'hE;
        disp_index_o = 4'd0;
        rd_lsb       = int'(vbyte_q) * DATA_W;
        case (state_q)
            S_LOAD: begin
                disp_byte_o  = data_i;
                disp_tag_o   = 4'hA + {1'b0, op_q};
                disp_index_o = byte_q + 4'd1;
            end
            S_VIEW: begin
                disp_byte_o  = result_q[rd_lsb +: DATA_W];
                disp_tag_o   = 4'hC;
                disp_index_o = vbyte_q + 4'd1;
            end
            default: begin
                disp_byte_o  = '0;
                disp_tag_o   = 4'hE;
                disp_index_o = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader
module tb_operand_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default configuration: 2 operands x 32 bits
    logic       rst, btn_next, btn_back, loaddata;
    logic [7:0] data, disp_byte;
    logic [3:0] disp_tag, disp_index;
    operand_loader_if #(.NUM_OPERANDS(2), .OPERAND_W(32), .RESULT_W(32)) bus ();

    operand_loader #(.DATA_W(8), .OPERAND_W(32), .NUM_OPERANDS(2), .RESULT_W(32)) dut (
        .clk(clk), .rst(rst), .btn_next_i(btn_next), .btn_back_i(btn_back), .data_i(data),
        .core_if(bus), .loaddata_o(loaddata), .disp_byte_o(disp_byte),
        .disp_tag_o(disp_tag), .disp_index_o(disp_index)
    );

    // Second configuration: 3 operands x 16 bits
    logic       rst6, btn_next6, btn_back6, loaddata6;
    logic [7:0] data6, disp_byte6;
    logic [3:0] disp_tag6, disp_index6;
    operand_loader_if #(.NUM_OPERANDS(3), .OPERAND_W(16), .RESULT_W(32)) bus6 ();

    operand_loader #(.DATA_W(8), .OPERAND_W(16), .NUM_OPERANDS(3), .RESULT_W(32)) dut6 (
        .clk(clk), .rst(rst6), .btn_next_i(btn_next6), .btn_back_i(btn_back6), .data_i(data6),
        .core_if(bus6), .loaddata_o(loaddata6), .disp_byte_o(disp_byte6),
        .disp_tag_o(disp_tag6), .disp_index_o(disp_index6)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_next(input logic [7:0] d);
        data = d; btn_next = 1'b1; cyc(6); btn_next = 1'b0; cyc(6);
    endtask

    task automatic press_back();
        btn_back = 1'b1; cyc(6); btn_back = 1'b0; cyc(6);
    endtask

    task automatic press_next6(input logic [7:0] d);
        data6 = d; btn_next6 = 1'b1; cyc(6); btn_next6 = 1'b0; cyc(6);
    endtask

    task automatic press_back6();
        btn_back6 = 1'b1; cyc(6); btn_back6 = 1'b0; cyc(6);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    endtask

    task automatic test_reset();
        data = 8'h5A;
        do_reset();
        checks++; if (loaddata !== 1'b1 || bus.operands_valid !== 1'b0) begin errors++;
            $display("FAIL reset_ctrl: loaddata=%b valid=%b expected 1/0", loaddata, bus.operands_valid); end
        checks++; if ({disp_tag, disp_index} !== 8'hA1) begin errors++;
            $display("FAIL reset_pos: got %h expected a1", {disp_tag, disp_index}); end
        checks++; if (bus.operands !== 64'h0) begin errors++;
            $display("FAIL reset_operands: got %h expected 0", bus.operands); end
        checks++; if (disp_byte !== 8'h5A) begin errors++;
            $display("FAIL reset_disp_live: got %h expected 5a", disp_byte); end
    endtask

    task automatic test_load_send();
        logic [7:0] exp_pos;
        for (int i = 0; i < 8; i++) begin
            press_next(8'((i + 1) * 17));
            if (i < 7) begin
                exp_pos = {4'hA + 4'((i + 1) / 4), 4'((i + 1) % 4 + 1)};
                checks++; if ({disp_tag, disp_index} !== exp_pos) begin errors++;
                    $display("FAIL load_pos%0d: got %h expected %h", i, {disp_tag, disp_index}, exp_pos); end
            end
        end
        checks++; if ({disp_tag, disp_index} !== 8'hE0) begin errors++;
            $display("FAIL send_pos: got %h expected e0", {disp_tag, disp_index}); end
        checks++; if (bus.operands_valid !== 1'b1 || loaddata !== 1'b0) begin errors++;
            $display("FAIL send_ctrl: valid=%b loaddata=%b expected 1/0", bus.operands_valid, loaddata); end
        checks++; if (bus.operands !== 64'h88776655_44332211) begin errors++;
            $display("FAIL send_operands: got %h expected 8877665544332211", bus.operands); end
    endtask

    task automatic test_handshake();
        logic [7:0] exp_b [4] = '{8'hBE, 8'hAD, 8'hDE, 8'hEF};
        logic [3:0] exp_i [4] = '{4'd2, 4'd3, 4'd4, 4'd1};
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++; if (bus.operands_valid !== 1'b1 || bus.operands !== 64'h88776655_44332211) begin errors++;
                $display("FAIL hold_valid%0d: valid=%b ops=%h expected 1/8877665544332211", i, bus.operands_valid, bus.operands); end
        end
        bus.operands_ready = 1'b1; cyc(1); bus.operands_ready = 1'b0;
        checks++; if (bus.operands_valid !== 1'b0 || {disp_tag, disp_index} !== 8'hE0) begin errors++;
            $display("FAIL xfer_drop: valid=%b pos=%h expected 0/e0", bus.operands_valid, {disp_tag, disp_index}); end
        cyc(2);
        bus.result = 32'hDEADBEEF; bus.result_valid = 1'b1; cyc(1);
        bus.result_valid = 1'b0; bus.result = 32'h0; cyc(1);
        checks++; if ({disp_tag, disp_index, disp_byte} !== 16'hC1EF) begin errors++;
            $display("FAIL view_first: got %h expected c1ef", {disp_tag, disp_index, disp_byte}); end
        for (int i = 0; i < 4; i++) begin
            press_next(8'h00);
            checks++; if ({disp_index, disp_byte} !== {exp_i[i], exp_b[i]}) begin errors++;
                $display("FAIL view_page%0d: got %h expected %h", i, {disp_index, disp_byte}, {exp_i[i], exp_b[i]}); end
        end
        bus.result = 32'h11111111; bus.result_valid = 1'b1; cyc(2); bus.result_valid = 1'b0; cyc(1);
        checks++; if (disp_byte !== 8'hEF) begin errors++;
            $display("FAIL view_hold: got %h expected ef", disp_byte); end
    endtask

    task automatic test_back();
        press_back();
        checks++; if (loaddata !== 1'b1 || {disp_tag, disp_index} !== 8'hA1 || bus.operands !== 64'h0) begin errors++;
            $display("FAIL view_back: ld=%b pos=%h ops=%h expected 1/a1/0", loaddata, {disp_tag, disp_index}, bus.operands); end
        press_next(8'h01); press_next(8'h02); press_back();
        checks++; if ({disp_tag, disp_index} !== 8'hA2) begin errors++;
            $display("FAIL back_a2: got %h expected a2", {disp_tag, disp_index}); end
        press_next(8'h0F);
        checks++; if (bus.operands !== 64'h0F01 || {disp_tag, disp_index} !== 8'hA3) begin errors++;
            $display("FAIL back_overwrite: ops=%h pos=%h expected f01/a3", bus.operands, {disp_tag, disp_index}); end
        do_reset(); press_back();
        checks++; if ({disp_tag, disp_index} !== 8'hA1 || bus.operands !== 64'h0) begin errors++;
            $display("FAIL back_origin: pos=%h ops=%h expected a1/0", {disp_tag, disp_index}, bus.operands); end
        for (int i = 0; i < 4; i++) press_next(8'((i + 1) * 17));
        checks++; if ({disp_tag, disp_index} !== 8'hB1) begin errors++;
            $display("FAIL reach_b1: got %h expected b1", {disp_tag, disp_index}); end
        press_back();
        checks++; if ({disp_tag, disp_index} !== 8'hA4 || bus.operands !== 64'h44332211) begin errors++;
            $display("FAIL back_cross: pos=%h ops=%h expected a4/44332211", {disp_tag, disp_index}, bus.operands); end
        press_next(8'h44);
        for (int i = 4; i < 8; i++) press_next(8'((i + 1) * 17));
        press_next(8'hAB);
        checks++; if ({disp_tag, disp_index} !== 8'hE0 || bus.operands !== 64'h88776655_44332211) begin errors++;
            $display("FAIL send_next_ignored: pos=%h ops=%h", {disp_tag, disp_index}, bus.operands); end
        press_back();
        checks++; if ({disp_tag, disp_index} !== 8'hB4 || bus.operands_valid !== 1'b0 || loaddata !== 1'b1) begin errors++;
            $display("FAIL send_back: pos=%h valid=%b ld=%b expected b4/0/1", {disp_tag, disp_index}, bus.operands_valid, loaddata); end
        press_next(8'h99);
        checks++; if (bus.operands_valid !== 1'b1 || bus.operands !== 64'h99776655_44332211) begin errors++;
            $display("FAIL resend: valid=%b ops=%h expected 1/9977665544332211", bus.operands_valid, bus.operands); end
    endtask

    task automatic test_hold();
        do_reset();
        data = 8'h77; btn_next = 1'b1; cyc(50); btn_next = 1'b0; cyc(6);
        checks++; if ({disp_tag, disp_index} !== 8'hA2 || bus.operands !== 64'h77) begin errors++;
            $display("FAIL hold_once: pos=%h ops=%h expected a2/77", {disp_tag, disp_index}, bus.operands); end
        data = 8'h55; btn_next = 1'b1; btn_back = 1'b1; cyc(8);
        btn_next = 1'b0; btn_back = 1'b0; cyc(6);
        checks++; if ({disp_tag, disp_index} !== 8'hA2 || bus.operands !== 64'h77) begin errors++;
            $display("FAIL both_ignored: pos=%h ops=%h expected a2/77", {disp_tag, disp_index}, bus.operands); end
        btn_next = 1'b1; rst = 1'b1; cyc(3); rst = 1'b0; cyc(10);
        checks++; if ({disp_tag, disp_index} !== 8'hA1 || bus.operands !== 64'h0) begin errors++;
            $display("FAIL held_thru_reset: pos=%h ops=%h expected a1/0", {disp_tag, disp_index}, bus.operands); end
        btn_next = 1'b0; cyc(6);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) press_next(8'((i + 1) * 17));
        checks++; if ({disp_tag, disp_index} !== 8'hB3) begin errors++;
            $display("FAIL reach_b3: got %h expected b3", {disp_tag, disp_index}); end
        rst = 1'b1; cyc(1);
        checks++; if ({disp_tag, disp_index} !== 8'hA1 || bus.operands !== 64'h0 || loaddata !== 1'b1 || bus.operands_valid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_load: pos=%h ops=%h ld=%b v=%b", {disp_tag, disp_index}, bus.operands, loaddata, bus.operands_valid); end
        rst = 1'b0; cyc(1);
        for (int i = 0; i < 8; i++) press_next(8'((i + 1) * 17));
        rst = 1'b1; cyc(1);
        checks++; if ({disp_tag, disp_index} !== 8'hA1 || bus.operands !== 64'h0 || loaddata !== 1'b1 || bus.operands_valid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_send: pos=%h ops=%h ld=%b v=%b", {disp_tag, disp_index}, bus.operands, loaddata, bus.operands_valid); end
        rst = 1'b0; cyc(1);
    endtask

    task automatic test_six();
        logic [7:0] exp_pos;
        rst6 = 1'b1; cyc(2); rst6 = 1'b0; cyc(1);
        checks++; if ({disp_tag6, disp_index6} !== 8'hA1) begin errors++;
            $display("FAIL six_reset: got %h expected a1", {disp_tag6, disp_index6}); end
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                bus6.operands_ready = 1'b1; bus6.result = 32'h12345678; bus6.result_valid = 1'b1;
            end
            press_next6(8'((i + 1) * 17));
            if (i < 5) begin
                exp_pos = {4'hA + 4'((i + 1) / 2), 4'((i + 1) % 2 + 1)};
                checks++; if ({disp_tag6, disp_index6} !== exp_pos) begin errors++;
                    $display("FAIL six_pos%0d: got %h expected %h", i, {disp_tag6, disp_index6}, exp_pos); end
            end
        end
        bus6.operands_ready = 1'b0; bus6.result_valid = 1'b0;
        checks++; if ({disp_tag6, disp_index6, disp_byte6} !== 16'hC178 || bus6.operands_valid !== 1'b0) begin errors++;
            $display("FAIL six_view: got %h v=%b expected c178/0", {disp_tag6, disp_index6, disp_byte6}, bus6.operands_valid); end
        checks++; if (bus6.operands !== 48'h6655_4433_2211) begin errors++;
            $display("FAIL six_operands: got %h expected 665544332211", bus6.operands); end
        press_back6();
        checks++; if ({disp_tag6, disp_index6} !== 8'hA1 || bus6.operands !== 48'h0 || loaddata6 !== 1'b1) begin errors++;
            $display("FAIL six_back: pos=%h ops=%h ld=%b expected a1/0/1", {disp_tag6, disp_index6}, bus6.operands, loaddata6); end
    endtask

    initial begin
        rst = 1'b1; btn_next = 1'b0; btn_back = 1'b0; data = 8'h00;
        bus.operands_ready = 1'b0; bus.result = 32'h0; bus.result_valid = 1'b0;
        rst6 = 1'b1; btn_next6 = 1'b0; btn_back6 = 1'b0; data6 = 8'h00;
        bus6.operands_ready = 1'b0; bus6.result = 32'h0; bus6.result_valid = 1'b0;
        test_reset();
        test_load_send();
        test_handshake();
        test_back();
        test_hold();
        test_reset_mid();
        test_six();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
